// File: rtl/shift_right_unit.sv
// Registered right-shift unit for the ALU datapath: logical, arithmetic,
// rotate or pass-through, with carry-out and zero flags one cycle later.
module shift_right_unit #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry,
    output logic             zero
);

    // Handshake: in_valid qualifies a/amt/mode on the rising edge; there is
    // no ready, every accepted operand yields exactly one out_valid pulse
    // on the following cycle, and idle cycles leave out/carry/zero held.

    typedef enum logic [1:0] {
        MODE_LSR  = 2'b00,
        MODE_ASR  = 2'b01,
        MODE_ROR  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    mode_e              mode_s;
    logic [AW-1:0]      amt_sat;
    logic [WIDTH-1:0]   lsr_res;
    logic [WIDTH-1:0]   asr_res;
    logic [WIDTH-1:0]   ror_res;
    logic [2*WIDTH-1:0] ror_wide;
    logic               carry_sh;

    logic [WIDTH-1:0]   out_d,   out_q;
    logic               carry_d, carry_q;
    logic               zero_d,  zero_q;
    logic               valid_q;

    assign mode_s = mode_e'(mode);

    // Distances beyond the operand width clamp to WIDTH-1 so carry stays meaningful.
    if (2**AW > WIDTH) begin : g_sat
        localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH - 1);
        assign amt_sat = (amt > AMT_MAX) ? AMT_MAX : amt;
    end else begin : g_nosat
        assign amt_sat = amt;
    end

    always_comb begin
        lsr_res  = a >> amt_sat;
        asr_res  = $unsigned($signed(a) >>> amt_sat);
        ror_wide = {a, a} >> amt_sat;
        ror_res  = ror_wide[WIDTH-1:0];

        carry_sh = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(amt_sat) == i + 1) carry_sh = a[i];
        end

        out_d   = a;
        carry_d = 1'b0;
        unique case (mode_s)
            MODE_LSR: begin
                out_d   = lsr_res;
                carry_d = carry_sh;
            end
            MODE_ASR: begin
                out_d   = asr_res;
                carry_d = carry_sh;
            end
            MODE_ROR: begin
                out_d   = ror_res;
                carry_d = carry_sh;
            end
            MODE_PASS: begin
                out_d   = a;
                carry_d = 1'b0;
            end
            default: begin
                out_d   = a;
                carry_d = 1'b0;
            end
        endcase

        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q   <= out_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Bench for shift_right_unit: a 4-bit and a saturating 5-bit instance checked
// every cycle against an arithmetic reference, plus literal expectations.
module tb_shift_right_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] mode;
    logic [3:0] a4;
    logic [1:0] amt4;
    logic [4:0] a5;
    logic [2:0] amt5;

    logic [3:0] out4;
    logic       ov4, c4, z4;
    logic [4:0] out5;
    logic       ov5, c5, z5;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];

    shift_right_unit #(.WIDTH(4), .AW(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .amt(amt4),
        .mode(mode), .out(out4), .out_valid(ov4), .carry(c4), .zero(z4)
    );

    shift_right_unit #(.WIDTH(5), .AW(3)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a5), .amt(amt5),
        .mode(mode), .out(out5), .out_valid(ov5), .carry(c5), .zero(z5)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: result of one operation on a w-bit operand
    function automatic void ref_calc(input int w, input int av, input int amt,
                                     input int md, output int o, output int c);
        int mask;
        int s;
        int sv;
        mask = (1 << w) - 1;
        s = (amt > w - 1) ? w - 1 : amt;
        case (md)
            0: o = av >> s;
            1: begin
                sv = ((av >> (w - 1)) & 1) != 0 ? av - (1 << w) : av;
                o  = (sv >>> s) & mask;
            end
            2: o = ((av | (av << w)) >> s) & mask;
            default: o = av;
        endcase
        c = (md == 3 || s == 0) ? 0 : ((av >> (s - 1)) & 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model state, updated like the outputs it predicts
    int m_out[2];
    bit m_c[2];
    bit m_z[2];
    bit m_v[2];

    always @(posedge clk or negedge rst_n) begin : model
        int o0, c0, o1, c1;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_out[i] <= 0;
                m_c[i]   <= 1'b0;
                m_z[i]   <= 1'b0;
                m_v[i]   <= 1'b0;
            end
        end else begin
            m_v[0] <= in_valid;
            m_v[1] <= in_valid;
            if (in_valid) begin
                ref_calc(4, int'(a4), int'(amt4), int'(mode), o0, c0);
                ref_calc(5, int'(a5), int'(amt5), int'(mode), o1, c1);
                m_out[0] <= o0;
                m_c[0]   <= c0[0];
                m_z[0]   <= (o0 == 0);
                m_out[1] <= o1;
                m_c[1]   <= c1[0];
                m_z[1]   <= (o1 == 0);
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        chk("w4_valid", 32'(ov4), 32'(m_v[0]));
        chk("w4_out",   32'(out4), m_out[0]);
        chk("w4_carry", 32'(c4), 32'(m_c[0]));
        chk("w4_zero",  32'(z4), 32'(m_z[0]));
        chk("w5_valid", 32'(ov5), 32'(m_v[1]));
        chk("w5_out",   32'(out5), m_out[1]);
        chk("w5_carry", 32'(c5), 32'(m_c[1]));
        chk("w5_zero",  32'(z5), 32'(m_z[1]));
    end

    // driver tasks
    task automatic apply(input logic v, input logic [3:0] av, input logic [1:0] am,
                         input logic [1:0] md);
        @(posedge clk);
        #1;
        in_valid = v;
        a4       = av;
        amt4     = am;
        mode     = md;
        a5       = 5'($urandom_range(0, 31));
        amt5     = 3'($urandom_range(0, 7));
    endtask

    // checks the result captured on the edge just before the current #1 point
    task automatic lit(input string name);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            chk({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_valid"}, 32'(ov4), 32'(e[6]));
            chk({name, "_out"},   32'(out4), 32'(e[5:2]));
            chk({name, "_carry"}, 32'(c4), 32'(e[1]));
            chk({name, "_zero"},  32'(z4), 32'(e[0]));
        end
    endtask

    initial begin : stim
        int o, c;

        // model pinned to hand-computed values
        ref_calc(4, 4'b1000, 2, 1, o, c);
        chk("ref_asr", o, 32'b1110);
        ref_calc(4, 4'b1011, 3, 2, o, c);
        chk("ref_ror", o, 32'b0111);
        chk("ref_ror_c", c, 0);
        ref_calc(4, 4'b0001, 1, 0, o, c);
        chk("ref_lsr_c", c, 1);
        ref_calc(5, 5'b10110, 7, 0, o, c);
        chk("ref_sat_lsr", o, 32'b00001);
        ref_calc(5, 5'b11001, 6, 2, o, c);
        chk("ref_sat_ror", o, 32'b10011);
        chk("ref_sat_ror_c", c, 1);

        // reset held with valid input and a running clock
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mode     = 2'b00;
        a4       = 4'hF;
        amt4     = 2'd1;
        a5       = 5'h1F;
        amt5     = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out4), 0);
        chk("rst_valid", 32'(ov4), 0);
        chk("rst_carry", 32'(c4), 0);
        chk("rst_zero", 32'(z4), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed sequence; each lit() checks the previous apply
        apply(1'b1, 4'b0001, 2'd1, 2'b00); exp_q.push_back({1'b1, 4'b0000, 1'b1, 1'b1});
        apply(1'b1, 4'b1000, 2'd1, 2'b00); lit("lsr_0001"); exp_q.push_back({1'b1, 4'b0100, 1'b0, 1'b0});
        apply(1'b1, 4'b0010, 2'd1, 2'b00); lit("lsr_1000"); exp_q.push_back({1'b1, 4'b0001, 1'b0, 1'b0});
        apply(1'b1, 4'b1000, 2'd2, 2'b01); lit("lsr_0010"); exp_q.push_back({1'b1, 4'b1110, 1'b0, 1'b0});
        apply(1'b1, 4'b1000, 2'd2, 2'b00); lit("asr_1000"); exp_q.push_back({1'b1, 4'b0010, 1'b0, 1'b0});
        apply(1'b1, 4'b1011, 2'd1, 2'b10); lit("lsr2_1000"); exp_q.push_back({1'b1, 4'b1101, 1'b1, 1'b0});
        apply(1'b1, 4'b1011, 2'd3, 2'b10); lit("ror1"); exp_q.push_back({1'b1, 4'b0111, 1'b0, 1'b0});
        apply(1'b1, 4'b0110, 2'd0, 2'b11); lit("ror3"); exp_q.push_back({1'b1, 4'b0110, 1'b0, 1'b0});
        apply(1'b1, 4'b0000, 2'd0, 2'b00); lit("pass"); exp_q.push_back({1'b1, 4'b0000, 1'b0, 1'b1});
        apply(1'b1, 4'b1000, 2'd1, 2'b00); lit("amt0"); exp_q.push_back({1'b1, 4'b0100, 1'b0, 1'b0});
        apply(1'b0, 4'b1111, 2'd1, 2'b00); lit("pre_hold"); exp_q.push_back({1'b0, 4'b0100, 1'b0, 1'b0});
        apply(1'b0, 4'b1111, 2'd2, 2'b01); lit("hold");

        // randomized traffic with one asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("async_rst_out", 32'(out4), 0);
                chk("async_rst_valid", 32'(ov4), 0);
                chk("async_rst_carry", 32'(c4), 0);
                chk("async_rst_zero", 32'(z4), 0);
                chk("async_rst_valid5", 32'(ov5), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        apply(1'b0, 4'd0, 2'd0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_unit.md
Name: shift_right_unit

Overview:
- Registered right-shift unit for the 4-bit ALU datapath.
- Takes an operand, shift amount and shift mode; produces the shifted result plus status flags one clock later.
- Default use is logical shift right by one: 0001->0000, 1000->0100, 0010->0001.
- Sits beside the adder/logic units and feeds the ALU result mux.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- AW, 2, shift-amount width; must satisfy 2**AW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/controls valid this cycle.
- a  input  WIDTH  operand.
- amt  input  AW  shift distance, 0..WIDTH-1.
- mode  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 pass-through.
- out  output  WIDTH  registered result.
- out_valid  output  1  out/flags valid.
- carry  output  1  last bit shifted out of bit 0.
- zero  output  1  out == 0.

Behaviour:
- Reset: rst_n low asynchronously clears out, out_valid, carry and zero to 0 immediately, independent of clk.
  - First capture occurs on the first rising edge after rst_n deasserts.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1, out/carry/zero are loaded from the current a/amt/mode and out_valid<=1.
- On a rising edge with in_valid=0, out_valid<=0 and out/carry/zero hold their previous values.
- No backpressure. Every valid input produces one result; back-to-back valids give back-to-back results.
- Logical (00): out = a >> amt, vacated MSBs filled with 0.
- Arithmetic (01): out = a >> amt, vacated MSBs filled with a[WIDTH-1].
- Rotate (10): out = {a, a} >> amt, low WIDTH bits; bits leaving bit 0 re-enter at the MSB.
- Pass (11): out = a, carry = 0.
- carry:
  - For amt > 0 in modes 00/01/10, carry = a[amt-1].
  - For amt = 0, carry = 0 in all modes.
- zero = (registered out == 0). It is computed from the next-state result, so it aligns with out in the same cycle.
- amt >= WIDTH: only possible when 2**AW > WIDTH. Treated as amt = WIDTH-1 (saturate); carry follows the saturated amount.
- Reset asserted mid-operation discards any in-flight result; out_valid is 0 while rst_n is low.
- Pure synchronous datapath after reset: no latches, no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=1111 and clk toggling -> out=0000, out_valid=0, carry=0, zero=0. Assert rst_n low asynchronously between edges -> outputs clear without waiting for clk.
- Logical >>1: mode=00, amt=1, apply a=0001, then 1000, then 0010 on consecutive cycles with in_valid=1.
  - One cycle later, out=0000 (carry=1, zero=1), then 0100 (carry=0, zero=0), then 0001 (carry=0, zero=0).
  - out_valid stays 1 throughout.
- Arithmetic vs logical: a=1000, amt=2.
  - mode=01 -> out=1110, carry=0.
  - mode=00 -> out=0010, carry=0.
- Rotate: mode=10, a=1011.
  - amt=1 -> out=1101, carry=1.
  - amt=3 -> out=0111, carry=0.
- Pass and amt=0: mode=11, a=0110 -> out=0110, carry=0. mode=00, amt=0, a=0000 -> out=0000, carry=0, zero=1.
- Hold behaviour: after a valid result out=0100, drive in_valid=0 with a=1111 -> out_valid=0, out stays 0100, carry and zero unchanged.
